// File: rtl/can_ctrl_axil_regs.sv
// AXI4-Lite control/status register file for the CAN controller core: block
// handshake (start/done/idle/ready), scalar I/O registers, output capture, interrupt.
module can_ctrl_axil_regs #(
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 7,
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                            ACLK,
    input  logic                            ARESET_N,
    input  logic                            ACLK_EN,
    input  logic                            AWVALID,
    output logic                            AWREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR,
    input  logic                            WVALID,
    output logic                            WREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB,
    output logic                            BVALID,
    input  logic                            BREADY,
    output logic [1:0]                      BRESP,
    input  logic                            ARVALID,
    output logic                            ARREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR,
    output logic                            RVALID,
    input  logic                            RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]                      RRESP,
    output logic [31:0]                     axi_in_reg1,
    output logic [31:0]                     axi_in_reg2,
    output logic [31:0]                     axi_out_reg1_i,
    output logic [31:0]                     axi_out_reg2_i,
    input  logic [31:0]                     axi_out_reg1_o,
    input  logic                            axi_out_reg1_o_ap_vld,
    input  logic [31:0]                     axi_out_reg2_o,
    input  logic                            axi_out_reg2_o_ap_vld,
    input  logic [63:0]                     can_rx_data_buffer,
    input  logic                            can_rx_data_buffer_ap_vld,
    output logic                            ap_start,
    input  logic                            ap_done,
    input  logic                            ap_ready,
    input  logic                            ap_idle,
    output logic                            interrupt
);

    localparam int unsigned DW  = C_S_AXI_DATA_WIDTH;
    localparam int unsigned SW  = C_S_AXI_DATA_WIDTH / 8;
    localparam int unsigned WAW = C_S_AXI_ADDR_WIDTH - 2;

    // Word addresses (byte address >> 2)
    localparam logic [WAW-1:0] A_CTRL     = WAW'(32'h00 >> 2);
    localparam logic [WAW-1:0] A_GIE      = WAW'(32'h04 >> 2);
    localparam logic [WAW-1:0] A_IER      = WAW'(32'h08 >> 2);
    localparam logic [WAW-1:0] A_ISR      = WAW'(32'h0C >> 2);
    localparam logic [WAW-1:0] A_IN1      = WAW'(32'h10 >> 2);
    localparam logic [WAW-1:0] A_IN2      = WAW'(32'h18 >> 2);
    localparam logic [WAW-1:0] A_OUT1_I   = WAW'(32'h20 >> 2);
    localparam logic [WAW-1:0] A_OUT1_O   = WAW'(32'h28 >> 2);
    localparam logic [WAW-1:0] A_OUT1_VLD = WAW'(32'h2C >> 2);
    localparam logic [WAW-1:0] A_OUT2_I   = WAW'(32'h30 >> 2);
    localparam logic [WAW-1:0] A_OUT2_O   = WAW'(32'h38 >> 2);
    localparam logic [WAW-1:0] A_OUT2_VLD = WAW'(32'h3C >> 2);
    localparam logic [WAW-1:0] A_RX_LO    = WAW'(32'h40 >> 2);
    localparam logic [WAW-1:0] A_RX_HI    = WAW'(32'h44 >> 2);
    localparam logic [WAW-1:0] A_RX_VLD   = WAW'(32'h48 >> 2);

    typedef enum logic [1:0] {WRRESET, WRIDLE, WRDATA, WRRESP} wr_state_e;
    typedef enum logic [1:0] {RDRESET, RDIDLE, RDDATA} rd_state_e;

    wr_state_e          wstate_q;
    rd_state_e          rstate_q;
    logic               awready_q, wready_q, bvalid_q;
    logic               arready_q, rvalid_q;
    logic [DW-1:0]      rdata_q, rdata_c;
    logic [WAW-1:0]     waddr_q;
    logic [WAW-1:0]     rd_word;
    logic [DW-1:0]      wmask;
    logic               w_hs, ar_hs, wr_ctl;

    logic               ap_start_q, ap_start_d;
    logic               auto_restart_q, auto_restart_d;
    logic               done_q, done_d;
    logic               gie_q, gie_d;
    logic [1:0]         ier_q, ier_d;
    logic [1:0]         isr_q, isr_d;
    logic               irq_q, irq_d;
    logic [31:0]        in1_q, in1_d, in2_q, in2_d;
    logic [31:0]        out1i_q, out1i_d, out2i_q, out2i_d;
    logic [31:0]        out1_q, out1_d, out2_q, out2_d;
    logic               out1v_q, out1v_d, out2v_q, out2v_d;
    logic [63:0]        rx_q, rx_d;
    logic               rxv_q, rxv_d;
    logic               unused_addr_lsbs;

    assign unused_addr_lsbs = ^{AWADDR[1:0], ARADDR[1:0]};

    assign w_hs    = WVALID & wready_q;
    assign ar_hs   = ARVALID & arready_q;
    assign wr_ctl  = w_hs & WSTRB[0];
    assign rd_word = ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

    always_comb begin
        wmask = '0;
        for (int b = 0; b < SW; b++) begin
            wmask[b*8 +: 8] = {8{WSTRB[b]}};
        end
    end

    // Write channel: address latched on AW, register update on W, hold B until BREADY
    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            wstate_q  <= WRRESET;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            waddr_q   <= '0;
        end else if (ACLK_EN) begin
            case (wstate_q)
                WRRESET: begin
                    wstate_q  <= WRIDLE;
                    awready_q <= 1'b1;
                end
                WRIDLE: if (AWVALID) begin
                    wstate_q  <= WRDATA;
                    awready_q <= 1'b0;
                    wready_q  <= 1'b1;
                    waddr_q   <= AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
                end
                WRDATA: if (WVALID) begin
                    wstate_q <= WRRESP;
                    wready_q <= 1'b0;
                    bvalid_q <= 1'b1;
                end
                WRRESP: if (BREADY) begin
                    wstate_q  <= WRIDLE;
                    bvalid_q  <= 1'b0;
                    awready_q <= 1'b1;
                end
            endcase
        end
    end

    // Read channel: data captured on AR, held until RREADY
    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            rstate_q  <= RDRESET;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else if (ACLK_EN) begin
            case (rstate_q)
                RDRESET: begin
                    rstate_q  <= RDIDLE;
                    arready_q <= 1'b1;
                end
                RDIDLE: if (ARVALID) begin
                    rstate_q  <= RDDATA;
                    arready_q <= 1'b0;
                    rvalid_q  <= 1'b1;
                    rdata_q   <= rdata_c;
                end
                RDDATA: if (RREADY) begin
                    rstate_q  <= RDIDLE;
                    rvalid_q  <= 1'b0;
                    arready_q <= 1'b1;
                end
                default: rstate_q <= RDRESET;
            endcase
        end
    end

    always_comb begin
        rdata_c = '0;
        case (rd_word)
            A_CTRL: begin
                rdata_c[0] = ap_start_q;
                rdata_c[1] = done_q;
                rdata_c[2] = ap_idle;
                rdata_c[3] = ap_ready;
                rdata_c[7] = auto_restart_q;
            end
            A_GIE:      rdata_c[0]   = gie_q;
            A_IER:      rdata_c[1:0] = ier_q;
            A_ISR:      rdata_c[1:0] = isr_q;
            A_IN1:      rdata_c      = in1_q;
            A_IN2:      rdata_c      = in2_q;
            A_OUT1_I:   rdata_c      = out1i_q;
            A_OUT1_O:   rdata_c      = out1_q;
            A_OUT1_VLD: rdata_c[0]   = out1v_q;
            A_OUT2_I:   rdata_c      = out2i_q;
            A_OUT2_O:   rdata_c      = out2_q;
            A_OUT2_VLD: rdata_c[0]   = out2v_q;
            A_RX_LO:    rdata_c      = rx_q[31:0];
            A_RX_HI:    rdata_c      = rx_q[63:32];
            A_RX_VLD:   rdata_c[0]   = rxv_q;
            default:    rdata_c      = '0;
        endcase
    end

    // Register next-state: in every set/clear pair the set is applied last so it wins
    always_comb begin
        ap_start_d     = ap_start_q;
        auto_restart_d = auto_restart_q;
        done_d         = done_q;
        gie_d          = gie_q;
        ier_d          = ier_q;
        isr_d          = isr_q;
        in1_d          = in1_q;
        in2_d          = in2_q;
        out1i_d        = out1i_q;
        out2i_d        = out2i_q;
        out1_d         = out1_q;
        out1v_d        = out1v_q;
        out2_d         = out2_q;
        out2v_d        = out2v_q;
        rx_d           = rx_q;
        rxv_d          = rxv_q;

        if (ap_ready && !auto_restart_q) ap_start_d = 1'b0;
        if (wr_ctl && waddr_q == A_CTRL) begin
            if (WDATA[0]) ap_start_d = 1'b1;
            auto_restart_d = WDATA[7];
        end
        if (ar_hs && rd_word == A_CTRL) done_d = 1'b0;
        if (ap_done) done_d = 1'b1;

        if (wr_ctl && waddr_q == A_GIE) gie_d = WDATA[0];
        if (wr_ctl && waddr_q == A_IER) ier_d = WDATA[1:0];
        if (wr_ctl && waddr_q == A_ISR) isr_d = isr_q ^ WDATA[1:0];
        if (ap_done && ier_q[0])  isr_d[0] = 1'b1;
        if (ap_ready && ier_q[1]) isr_d[1] = 1'b1;

        if (w_hs && waddr_q == A_IN1)    in1_d   = (WDATA & wmask) | (in1_q & ~wmask);
        if (w_hs && waddr_q == A_IN2)    in2_d   = (WDATA & wmask) | (in2_q & ~wmask);
        if (w_hs && waddr_q == A_OUT1_I) out1i_d = (WDATA & wmask) | (out1i_q & ~wmask);
        if (w_hs && waddr_q == A_OUT2_I) out2i_d = (WDATA & wmask) | (out2i_q & ~wmask);

        if (ar_hs && rd_word == A_OUT1_VLD) out1v_d = 1'b0;
        if (axi_out_reg1_o_ap_vld) begin
            out1_d  = axi_out_reg1_o;
            out1v_d = 1'b1;
        end
        if (ar_hs && rd_word == A_OUT2_VLD) out2v_d = 1'b0;
        if (axi_out_reg2_o_ap_vld) begin
            out2_d  = axi_out_reg2_o;
            out2v_d = 1'b1;
        end
        if (ar_hs && rd_word == A_RX_VLD) rxv_d = 1'b0;
        if (can_rx_data_buffer_ap_vld) begin
            rx_d  = can_rx_data_buffer;
            rxv_d = 1'b1;
        end
    end

    // Interrupt follows the register state being written on the same edge
    assign irq_d = gie_d & |(ier_d & isr_d);

    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            ap_start_q     <= 1'b0;
            auto_restart_q <= 1'b0;
            done_q         <= 1'b0;
            gie_q          <= 1'b0;
            ier_q          <= '0;
            isr_q          <= '0;
            irq_q          <= 1'b0;
            in1_q          <= '0;
            in2_q          <= '0;
            out1i_q        <= '0;
            out2i_q        <= '0;
            out1_q         <= '0;
            out1v_q        <= 1'b0;
            out2_q         <= '0;
            out2v_q        <= 1'b0;
            rx_q           <= '0;
            rxv_q          <= 1'b0;
        end else if (ACLK_EN) begin
            ap_start_q     <= ap_start_d;
            auto_restart_q <= auto_restart_d;
            done_q         <= done_d;
            gie_q          <= gie_d;
            ier_q          <= ier_d;
            isr_q          <= isr_d;
            irq_q          <= irq_d;
            in1_q          <= in1_d;
            in2_q          <= in2_d;
            out1i_q        <= out1i_d;
            out2i_q        <= out2i_d;
            out1_q         <= out1_d;
            out1v_q        <= out1v_d;
            out2_q         <= out2_d;
            out2v_q        <= out2v_d;
            rx_q           <= rx_d;
            rxv_q          <= rxv_d;
        end
    end

    assign AWREADY        = awready_q;
    assign WREADY         = wready_q;
    assign BVALID         = bvalid_q;
    assign BRESP          = 2'b00;
    assign ARREADY        = arready_q;
    assign RVALID         = rvalid_q;
    assign RDATA          = rdata_q;
    assign RRESP          = 2'b00;
    assign axi_in_reg1    = in1_q;
    assign axi_in_reg2    = in2_q;
    assign axi_out_reg1_i = out1i_q;
    assign axi_out_reg2_i = out2i_q;
    assign ap_start       = ap_start_q;
    assign interrupt      = irq_q;

endmodule

// File: tb/tb_can_ctrl_axil_regs.sv
// Bench for can_ctrl_axil_regs: directed AXI-Lite traffic, a register-map model
// checked every cycle, and hand-computed literal expectations.
module tb_can_ctrl_axil_regs;

    logic        ACLK = 1'b0;
    logic        ARESET_N, ACLK_EN;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [6:0]  AWADDR, ARADDR;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;
    logic [31:0] axi_in_reg1, axi_in_reg2, axi_out_reg1_i, axi_out_reg2_i;
    logic [31:0] axi_out_reg1_o, axi_out_reg2_o;
    logic        axi_out_reg1_o_ap_vld, axi_out_reg2_o_ap_vld;
    logic [63:0] can_rx_data_buffer;
    logic        can_rx_data_buffer_ap_vld;
    logic        ap_start, ap_done, ap_ready, ap_idle, interrupt;

    int checks = 0;
    int failures = 0;

    always #5 ACLK = ~ACLK;

    can_ctrl_axil_regs dut (
        .ACLK(ACLK), .ARESET_N(ARESET_N), .ACLK_EN(ACLK_EN),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .axi_in_reg1(axi_in_reg1), .axi_in_reg2(axi_in_reg2),
        .axi_out_reg1_i(axi_out_reg1_i), .axi_out_reg2_i(axi_out_reg2_i),
        .axi_out_reg1_o(axi_out_reg1_o), .axi_out_reg1_o_ap_vld(axi_out_reg1_o_ap_vld),
        .axi_out_reg2_o(axi_out_reg2_o), .axi_out_reg2_o_ap_vld(axi_out_reg2_o_ap_vld),
        .can_rx_data_buffer(can_rx_data_buffer),
        .can_rx_data_buffer_ap_vld(can_rx_data_buffer_ap_vld),
        .ap_start(ap_start), .ap_done(ap_done), .ap_ready(ap_ready), .ap_idle(ap_idle),
        .interrupt(interrupt)
    );

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endfunction

    // Register-map model, indexed by word address
    logic [31:0] m_rw [0:31];
    logic        m_start = 0, m_auto = 0, m_done = 0, m_gie = 0;
    logic [1:0]  m_ier = 0, m_isr = 0;
    logic [31:0] m_out1 = 0, m_out2 = 0;
    logic        m_out1v = 0, m_out2v = 0, m_rxv = 0;
    logic [63:0] m_rx = 0;
    logic [4:0]  m_waddr = 0;
    logic [31:0] exp_q [$];
    logic [1:0]  old_ier;
    logic        old_auto, rd_hit;
    logic [4:0]  rd_w;

    initial for (int i = 0; i < 32; i++) m_rw[i] = '0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] w);
        logic [31:0] r;
        case (w)
            5'd0:  r = {24'd0, m_auto, 3'd0, ap_ready, ap_idle, m_done, m_start};
            5'd1:  r = {31'd0, m_gie};
            5'd2:  r = {30'd0, m_ier};
            5'd3:  r = {30'd0, m_isr};
            5'd4, 5'd6, 5'd8, 5'd12: r = m_rw[w];
            5'd10: r = m_out1;
            5'd11: r = {31'd0, m_out1v};
            5'd14: r = m_out2;
            5'd15: r = {31'd0, m_out2v};
            5'd16: r = m_rx[31:0];
            5'd17: r = m_rx[63:32];
            5'd18: r = {31'd0, m_rxv};
            default: r = '0;
        endcase
        return r;
    endfunction

    always @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            m_start = 0; m_auto = 0; m_done = 0; m_gie = 0; m_ier = 0; m_isr = 0;
            m_out1 = 0; m_out2 = 0; m_out1v = 0; m_out2v = 0; m_rx = 0; m_rxv = 0;
            m_waddr = 0;
            for (int i = 0; i < 32; i++) m_rw[i] = '0;
            exp_q.delete();
        end else if (ACLK_EN) begin
            old_ier  = m_ier;
            old_auto = m_auto;
            rd_hit   = ARVALID && ARREADY;
            rd_w     = ARADDR[6:2];
            if (RVALID && RREADY && exp_q.size() > 0) void'(exp_q.pop_front());
            if (rd_hit) exp_q.push_back(model_read(rd_w));
            if (ap_ready && !old_auto) m_start = 0;
            if (WVALID && WREADY) begin
                case (m_waddr)
                    5'd0: if (WSTRB[0]) begin
                        if (WDATA[0]) m_start = 1;
                        m_auto = WDATA[7];
                    end
                    5'd1: if (WSTRB[0]) m_gie = WDATA[0];
                    5'd2: if (WSTRB[0]) m_ier = WDATA[1:0];
                    5'd3: if (WSTRB[0]) m_isr = m_isr ^ WDATA[1:0];
                    5'd4, 5'd6, 5'd8, 5'd12: m_rw[m_waddr] = merge(m_rw[m_waddr], WDATA, WSTRB);
                    default: ;
                endcase
            end
            if (AWVALID && AWREADY) m_waddr = AWADDR[6:2];
            if (rd_hit && rd_w == 5'd0) m_done = 0;
            if (ap_done) m_done = 1;
            if (ap_done && old_ier[0]) m_isr[0] = 1;
            if (ap_ready && old_ier[1]) m_isr[1] = 1;
            if (rd_hit && rd_w == 5'd11) m_out1v = 0;
            if (axi_out_reg1_o_ap_vld) begin m_out1 = axi_out_reg1_o; m_out1v = 1; end
            if (rd_hit && rd_w == 5'd15) m_out2v = 0;
            if (axi_out_reg2_o_ap_vld) begin m_out2 = axi_out_reg2_o; m_out2v = 1; end
            if (rd_hit && rd_w == 5'd18) m_rxv = 0;
            if (can_rx_data_buffer_ap_vld) begin m_rx = can_rx_data_buffer; m_rxv = 1; end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge ACLK) begin
        check("m_ap_start", ap_start, m_start);
        check("m_interrupt", interrupt, m_gie & |(m_ier & m_isr));
        check("m_in_reg1", axi_in_reg1, m_rw[4]);
        check("m_in_reg2", axi_in_reg2, m_rw[6]);
        check("m_out_reg1_i", axi_out_reg1_i, m_rw[8]);
        check("m_out_reg2_i", axi_out_reg2_i, m_rw[12]);
        if (BVALID) check("m_bresp", BRESP, 2'b00);
        if (RVALID) begin
            check("m_rresp", RRESP, 2'b00);
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL m_rdata unexpected RVALID actual=%h required=none", RDATA);
            end else begin
                check("m_rdata", RDATA, exp_q[0]);
            end
        end
    end

    task automatic axi_write(input logic [6:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input bit with_ready);
        int n;
        AWADDR = addr; AWVALID = 1; n = 0;
        while (!AWREADY && n < 50) begin @(posedge ACLK); #1; n++; end
        if (!AWREADY) begin
            checks++; failures++; AWVALID = 0;
            $display("FAIL aw_wait actual=timeout required=AWREADY");
            return;
        end
        @(posedge ACLK); #1;
        AWVALID = 0;
        WDATA = data; WSTRB = strb; WVALID = 1; ap_ready = with_ready;
        check("wready_lat", WREADY, 1);
        @(posedge ACLK); #1;
        WVALID = 0; ap_ready = 0;
        check("bvalid_lat", BVALID, 1);
        check("bresp", BRESP, 0);
        BREADY = 1;
        @(posedge ACLK); #1;
        BREADY = 0;
        check("bvalid_drop", BVALID, 0);
    endtask

    task automatic axi_read(input logic [6:0] addr, input int stall, input bit with_rx,
                            output logic [31:0] data);
        int n;
        data = 'x;
        ARADDR = addr; ARVALID = 1; n = 0;
        while (!ARREADY && n < 50) begin @(posedge ACLK); #1; n++; end
        if (!ARREADY) begin
            checks++; failures++; ARVALID = 0;
            $display("FAIL ar_wait actual=timeout required=ARREADY");
            return;
        end
        can_rx_data_buffer_ap_vld = with_rx;
        @(posedge ACLK); #1;
        ARVALID = 0; can_rx_data_buffer_ap_vld = 0;
        check("rvalid_lat", RVALID, 1);
        data = RDATA;
        for (int i = 0; i < stall; i++) begin
            @(posedge ACLK); #1;
            check("rvalid_hold", RVALID, 1);
            check("rdata_hold", RDATA, data);
            check("arready_hold", ARREADY, 0);
        end
        RREADY = 1;
        @(posedge ACLK); #1;
        RREADY = 0;
        check("rvalid_drop", RVALID, 0);
        check("arready_back", ARREADY, 1);
    endtask

    task automatic rd_expect(input string name, input logic [6:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        axi_read(addr, 0, 0, d);
        check(name, d, exp);
    endtask

    task automatic pulse(input bit done, input bit ready);
        ap_done = done; ap_ready = ready;
        @(posedge ACLK); #1;
        ap_done = 0; ap_ready = 0;
    endtask

    logic [31:0] d;

    initial begin
        ARESET_N = 0; ACLK_EN = 1;
        AWVALID = 0; AWADDR = 0; WVALID = 0; WDATA = 0; WSTRB = 0; BREADY = 0;
        ARVALID = 0; ARADDR = 0; RREADY = 0;
        axi_out_reg1_o = 0; axi_out_reg2_o = 0;
        axi_out_reg1_o_ap_vld = 0; axi_out_reg2_o_ap_vld = 0;
        can_rx_data_buffer = 0; can_rx_data_buffer_ap_vld = 0;
        ap_done = 0; ap_ready = 0; ap_idle = 1;

        repeat (3) @(posedge ACLK);
        #1;
        check("rst_awready", AWREADY, 0);
        check("rst_arready", ARREADY, 0);
        check("rst_bvalid", BVALID, 0);
        check("rst_rvalid", RVALID, 0);
        check("rst_ap_start", ap_start, 0);
        check("rst_interrupt", interrupt, 0);
        ARESET_N = 1;
        #1;
        check("rel_awready_0", AWREADY, 0);
        @(posedge ACLK); #1;
        check("rel_awready_1", AWREADY, 1);
        check("rel_arready_1", ARREADY, 1);

        rd_expect("ctrl_idle", 7'h00, 32'h4);

        axi_write(7'h10, 32'h12345678, 4'b0011, 0);
        check("in_reg1_strb", axi_in_reg1, 32'h00005678);
        rd_expect("rd_in_reg1", 7'h10, 32'h00005678);

        axi_write(7'h00, 32'h1, 4'hF, 0);
        check("ap_start_set", ap_start, 1);
        pulse(1, 1);
        check("ap_start_clr", ap_start, 0);
        rd_expect("ctrl_done_1", 7'h00, 32'h6);
        rd_expect("ctrl_done_cor", 7'h00, 32'h4);

        axi_write(7'h04, 32'h1, 4'hF, 0);
        axi_write(7'h08, 32'h1, 4'hF, 0);
        pulse(1, 0);
        check("irq_set", interrupt, 1);
        rd_expect("isr_rd", 7'h0C, 32'h1);
        axi_write(7'h0C, 32'h1, 4'hF, 0);
        check("irq_clr", interrupt, 0);

        can_rx_data_buffer = 64'hAABBCCDD_11223344;
        can_rx_data_buffer_ap_vld = 1;
        @(posedge ACLK); #1;
        can_rx_data_buffer_ap_vld = 0;
        rd_expect("rx_lo", 7'h40, 32'h11223344);
        rd_expect("rx_hi", 7'h44, 32'hAABBCCDD);
        rd_expect("rx_vld_1", 7'h48, 32'h1);
        rd_expect("rx_vld_cor", 7'h48, 32'h0);
        axi_read(7'h48, 0, 1, d);
        check("rx_vld_race_rd", d, 32'h0);
        rd_expect("rx_vld_set_wins", 7'h48, 32'h1);
        rd_expect("rx_vld_cor2", 7'h48, 32'h0);

        axi_read(7'h10, 3, 0, d);
        check("stall_rdata", d, 32'h00005678);

        axi_write(7'h00, 32'h1, 4'hF, 1);
        check("start_set_wins", ap_start, 1);
        pulse(0, 1);
        check("start_ready_clr", ap_start, 0);

        axi_write(7'h00, 32'h81, 4'hF, 0);
        pulse(0, 1);
        check("auto_restart_hold", ap_start, 1);
        axi_write(7'h00, 32'h0, 4'hF, 0);
        check("wr0_keeps_start", ap_start, 1);
        pulse(0, 1);
        check("auto_off_clr", ap_start, 0);

        rd_expect("ctrl_done_pending", 7'h00, 32'h6);
        ACLK_EN = 0;
        pulse(1, 0);
        ACLK_EN = 1;
        rd_expect("ctrl_clk_en_off", 7'h00, 32'h4);

        axi_write(7'h20, 32'hCAFEF00D, 4'hF, 0);
        check("out_reg1_i", axi_out_reg1_i, 32'hCAFEF00D);
        rd_expect("rd_out_reg1_i", 7'h20, 32'hCAFEF00D);
        axi_write(7'h30, 32'h0BADBEEF, 4'b1000, 0);
        check("out_reg2_i_strb", axi_out_reg2_i, 32'h0B000000);
        axi_write(7'h18, 32'hDEADBEEF, 4'b1100, 0);
        check("in_reg2_strb", axi_in_reg2, 32'hDEAD0000);
        axi_write(7'h14, 32'hFFFFFFFF, 4'hF, 0);
        check("unmapped_wr_in1", axi_in_reg1, 32'h00005678);
        rd_expect("unmapped_14", 7'h14, 32'h0);
        rd_expect("unmapped_50", 7'h50, 32'h0);

        axi_out_reg1_o = 32'h13572468; axi_out_reg1_o_ap_vld = 1;
        axi_out_reg2_o = 32'h89ABCDEF; axi_out_reg2_o_ap_vld = 1;
        @(posedge ACLK); #1;
        axi_out_reg1_o_ap_vld = 0; axi_out_reg2_o_ap_vld = 0;
        axi_out_reg1_o = 32'h0; axi_out_reg2_o = 32'h0;
        rd_expect("out1_data", 7'h28, 32'h13572468);
        rd_expect("out1_vld", 7'h2C, 32'h1);
        rd_expect("out1_vld_cor", 7'h2C, 32'h0);
        rd_expect("out2_data", 7'h38, 32'h89ABCDEF);
        rd_expect("out2_vld", 7'h3C, 32'h1);
        rd_expect("out2_vld_cor", 7'h3C, 32'h0);

        // Reset in the middle of a write: no response may appear
        AWADDR = 7'h10; AWVALID = 1;
        @(posedge ACLK); #1;
        AWVALID = 0;
        check("abort_wready", WREADY, 1);
        ARESET_N = 0;
        #1;
        check("abort_wready_rst", WREADY, 0);
        check("abort_bvalid", BVALID, 0);
        check("abort_in_reg1", axi_in_reg1, 0);
        repeat (2) @(posedge ACLK);
        #1;
        ARESET_N = 1;
        @(posedge ACLK); #1;
        check("abort_awready", AWREADY, 1);
        check("abort_bvalid_after", BVALID, 0);
        axi_write(7'h10, 32'hA5A5A5A5, 4'hF, 0);
        rd_expect("post_abort_rd", 7'h10, 32'hA5A5A5A5);

        repeat (2) @(posedge ACLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/can_ctrl_axil_regs.md
# can_ctrl_axil_regs

AXI4-Lite slave register file for the CAN controller core: it exposes the core's block-level handshake (start/done/idle/ready) and the core's scalar I/O registers to a host processor. It raises an interrupt on core completion. It sits between the SoC AXI-Lite interconnect and the core's FSM, one instance per core. Register behaviour follows the standard HLS control-port layout defined below.

## Interface
- C_S_AXI_ADDR_WIDTH, 7: byte address width.
- C_S_AXI_DATA_WIDTH, 32: data width; WSTRB width is DATA_WIDTH/8.
- Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET_N  in  1  reset, asynchronous, active-low.
- ACLK_EN  in  1  clock enable; no state changes when 0.
- AWVALID/AWREADY/AWADDR[6:0]: in/out/in, write address channel.
- WVALID/WREADY/WDATA[31:0]/WSTRB[3:0]: in/out/in/in, write data channel.
- BVALID/BREADY/BRESP[1:0]: out/in/out, write response channel.
- ARVALID/ARREADY/ARADDR[6:0]: in/out/in, read address channel.
- RVALID/RREADY/RDATA[31:0]/RRESP[1:0]: out/in/out/out, read data channel.
- axi_in_reg1, axi_in_reg2  out  32  host-written core inputs.
- axi_out_reg1_i, axi_out_reg2_i  out  32  host-written initial values of the core's in/out registers.
- axi_out_reg1_o/_ap_vld, axi_out_reg2_o/_ap_vld  in  32/1  core result and its valid strobe.
- can_rx_data_buffer/_ap_vld  in  64/1  core RX data and its valid strobe.
- ap_start  out  1; ap_done, ap_ready, ap_idle  in  1 each; interrupt  out  1.

## Operation
- Address map (word aligned; ADDR[1:0] ignored):
- 0x00 AP_CTRL: bit0 ap_start (RW), bit1 done (R, clear-on-read), bit2 idle (R, live), bit3 ready (R, live), bit7 auto_restart (RW).
- 0x04 GIE bit0. 0x08 IER bits[1:0] (0 = done, 1 = ready). 0x0C ISR bits[1:0]: a write toggles the bits set in WDATA.
- 0x10 axi_in_reg1 RW. 0x18 axi_in_reg2 RW. 0x20 axi_out_reg1_i RW. 0x30 axi_out_reg2_i RW.
- 0x28 axi_out_reg1_o R. 0x2C bit0 reg1 valid (clear-on-read). 0x38 axi_out_reg2_o R. 0x3C bit0 reg2 valid (clear-on-read).
- 0x40 can_rx_data_buffer[31:0] R. 0x44 can_rx_data_buffer[63:32] R. 0x48 bit0 rx valid (clear-on-read).
- Unmapped addresses read 0; writes to them are ignored. RW data registers apply WSTRB per byte.
- ap_start:
  - Set by writing 1 to AP_CTRL bit0.
  - Cleared when ap_ready=1 and auto_restart=0.
  - If a set and a clear occur in the same cycle, the set wins.
- done bit: set when ap_done=1; cleared after a read of 0x00. A set in the same cycle as the read wins.
- ISR[0] is set when ap_done & IER[0]; ISR[1] is set when ap_ready & IER[1]. interrupt = GIE & |(IER & ISR), registered.
- Output capture (each of reg1_o, reg2_o, rx buffer): when _ap_vld=1, latch the data and set the valid bit. The valid bit clears on a read of its control word; a set in the same cycle wins.
- BRESP = RRESP = 2'b00 always.

## Timing
- Write FSM: WRRESET → WRIDLE → WRDATA → WRRESP → WRIDLE.
  - AWREADY = (state==WRIDLE); WREADY = (state==WRDATA); BVALID = (state==WRRESP).
  - AWADDR is latched on the AW handshake; the register update happens on the W handshake.
  - The FSM stays in WRRESP until BREADY.
- Read FSM: RDRESET → RDIDLE → RDDATA → RDIDLE.
  - ARREADY = (state==RDIDLE).
  - RDATA is registered on the AR handshake; RVALID=1 in RDDATA until RREADY.
  - Clear-on-read side effects occur on the AR handshake.
- During reset, outputs are: AWREADY/WREADY/BVALID/ARREADY/RVALID=0, all registers 0, ap_start=0, interrupt=0. On the first enabled edge after deassertion, both FSMs move to IDLE.
- Reset asserted mid-transaction aborts it immediately; no response is issued.
- Latency:
  - Write: AW accepted at cycle N, W accepted at N+1 at earliest, BVALID at N+2.
  - Read: AR accepted at N, RVALID at N+1.

## Test plan
- Reset release: AWREADY/ARREADY go 1 one cycle after deassertion. Reading 0x00 with ap_idle=1 returns 0x4.
- Write 0x12345678 to 0x10 with WSTRB=4'b0011 (prior value 0) → axi_in_reg1=0x00005678, and a read of 0x10 returns the same. BRESP=0.
- Write 1 to 0x00 → ap_start=1. Pulse ap_ready+ap_done → ap_start=0. First read of 0x00 shows bit1=1; second read shows bit1=0.
- Set GIE=1, IER=1, then pulse ap_done → interrupt=1, ISR reads 0x1. Write 1 to 0x0C → interrupt=0.
- Pulse can_rx_data_buffer_ap_vld with 0xAABBCCDD_11223344 → 0x40=0x11223344, 0x44=0xAABBCCDD. 0x48 reads 1, then 0 on the next read.
- Hold RREADY=0 for 3 cycles → RVALID and RDATA stay stable and ARREADY stays 0 until RREADY rises.
